// File: rtl/beam_pkg.sv
// Shared constants and types for the delay-and-sum beam accumulator.
//   NUM_CH : mic channels per frame (power of two, >= 2)
//   DATA_W : signed PCM sample width
//   SHIFT  : log2(NUM_CH), the divide used by the average
//   SUM_W  : accumulator width; NUM_CH samples summed cannot overflow it
package beam_pkg;

    localparam int unsigned NUM_CH = 16;
    localparam int unsigned DATA_W = 19;
    localparam int unsigned SHIFT  = $clog2(NUM_CH);
    localparam int unsigned SUM_W  = DATA_W + SHIFT;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        OUTPUT
    } beam_sum_state_t;

    typedef logic signed [DATA_W-1:0] beam_sample_t;

endpackage

// File: rtl/beam_round_shift.sv
// Rounded average: (acc + 2^(SHIFT_AMT-1)) >>> SHIFT_AMT, round-half-up,
// truncated to OUT_WIDTH. Purely combinational.
//   acc_i : signed accumulator value, SUM_WIDTH bits
//   avg_o : signed rounded average, OUT_WIDTH bits
module beam_round_shift
    import beam_pkg::*;
#(
    parameter int unsigned SUM_WIDTH = SUM_W,
    parameter int unsigned SHIFT_AMT = SHIFT,
    parameter int unsigned OUT_WIDTH = DATA_W
) (
    input  logic signed [SUM_WIDTH-1:0] acc_i,
    output logic signed [OUT_WIDTH-1:0] avg_o
);

    localparam logic [SUM_WIDTH-1:0] HALF = SUM_WIDTH'(64'(1) << (SHIFT_AMT - 1));

    // Biased sum cannot wrap: max positive sum + HALF stays below 2^(SUM_WIDTH-1).
    logic signed [SUM_WIDTH-1:0] biased;

    assign biased = acc_i + $signed(HALF);
    assign avg_o  = OUT_WIDTH'(biased >>> SHIFT_AMT);

endmodule

// File: rtl/beam_sum_accumulator.sv
// Delay-and-sum back end: captures one frame of NUM_CH signed samples per
// input handshake, adds them serially one channel per cycle, then presents
// the full-precision sum and a rounded average until the output handshake.
// Optional macro BEAM_CHANNEL_MASK_EN adds ch_mask; masked channels add 0.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : frame handshake, in_data packed channel i at [i*DATA_W +: DATA_W]
//   ch_mask             : (macro only) per-channel enable, sampled with in_data
//   out_valid/out_ready : result handshake
//   out_sum, out_avg    : registered sum and rounded average
//   busy                : high while accumulating or holding a result
module beam_sum_accumulator
    import beam_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_CH*DATA_W-1:0]   in_data,
`ifdef BEAM_CHANNEL_MASK_EN
    input  logic [NUM_CH-1:0]          ch_mask,
`endif
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [SUM_W-1:0]    out_sum,
    output logic signed [DATA_W-1:0]   out_avg,
    output logic                       busy
);

    localparam logic [SHIFT-1:0] LAST_IDX = SHIFT'(NUM_CH - 1);

    beam_sum_state_t          state_q;
    beam_sample_t             frame_q [NUM_CH];
    logic signed [SUM_W-1:0]  acc_q;
    logic [SHIFT-1:0]         idx_q;
    logic                     in_ready_q;
    logic                     out_valid_q;
    logic                     busy_q;
    logic signed [SUM_W-1:0]  out_sum_q;
    logic signed [DATA_W-1:0] out_avg_q;
`ifdef BEAM_CHANNEL_MASK_EN
    logic [NUM_CH-1:0]        mask_q;
`endif

    beam_sample_t             sample_c;
    logic signed [SUM_W-1:0]  acc_d;
    logic signed [DATA_W-1:0] avg_c;

    // Channel select; a masked channel contributes zero but still costs a cycle.
`ifdef BEAM_CHANNEL_MASK_EN
    assign sample_c = mask_q[idx_q] ? frame_q[idx_q] : '0;
`else
    assign sample_c = frame_q[idx_q];
`endif

    assign acc_d = acc_q + {{SHIFT{sample_c[DATA_W-1]}}, sample_c};

    // Average is taken from acc_d so it is ready on the same edge as out_sum.
    beam_round_shift #(
        .SUM_WIDTH (SUM_W),
        .SHIFT_AMT (SHIFT),
        .OUT_WIDTH (DATA_W)
    ) u_round_shift (
        .acc_i (acc_d),
        .avg_o (avg_c)
    );

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_sum_q   <= '0;
            out_avg_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                frame_q[i] <= '0;
            end
`ifdef BEAM_CHANNEL_MASK_EN
            mask_q      <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            frame_q[i] <= in_data[i*DATA_W +: DATA_W];
                        end
`ifdef BEAM_CHANNEL_MASK_EN
                        mask_q     <= ch_mask;
`endif
                        acc_q      <= '0;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc_q <= acc_d;
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        out_sum_q   <= acc_d;
                        out_avg_q   <= avg_c;
                        out_valid_q <= 1'b1;
                        state_q     <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_sum   = out_sum_q;
    assign out_avg   = out_avg_q;

endmodule

// File: tb/tb_beam_sum_accumulator.sv
// Self-checking bench for beam_sum_accumulator: directed frames from the
// test plan plus random frames, compared against a plain-arithmetic model.
module tb_beam_sum_accumulator;
    import beam_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     in_valid;
    logic                     in_ready;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        ch_mask;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [SUM_W-1:0]  out_sum;
    logic signed [DATA_W-1:0] out_avg;
    logic                     busy;

    int errors = 0;
    int checks = 0;

    int                smp [NUM_CH];
    logic [NUM_CH-1:0] msk;

    always #5 clk = ~clk;

    beam_sum_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
`ifdef BEAM_CHANNEL_MASK_EN
        .ch_mask   (ch_mask),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_avg   (out_avg),
        .busy      (busy)
    );

    task automatic check_eq(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: sum of enabled channels, then round-half-up divide by NUM_CH.
    function automatic longint model_sum();
        longint s = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (msk[i]) s += smp[i];
        end
        return s;
    endfunction

    function automatic longint model_avg(input longint s);
        longint t = s + NUM_CH / 2;
        if (t >= 0) return t / NUM_CH;
        return -((-t + NUM_CH - 1) / NUM_CH);
    endfunction

    function automatic logic [NUM_CH*DATA_W-1:0] pack_frame();
        logic [NUM_CH*DATA_W-1:0] v;
        for (int i = 0; i < NUM_CH; i++) begin
            v[i*DATA_W +: DATA_W] = DATA_W'(smp[i]);
        end
        return v;
    endfunction

    task automatic wait_in_ready(input string tag);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check_eq({tag, "_in_ready_timeout"}, 0, 1);
    endtask

    // Drive one frame; hold_ready applies 5 cycles of back-pressure.
    task automatic run_frame(input string tag, input bit hold_ready);
        longint es;
        longint ea;
        int     lat;
        es = model_sum();
        ea = model_avg(es);
        wait_in_ready(tag);
        @(negedge clk);
        in_data   = pack_frame();
        ch_mask   = msk;
        in_valid  = 1'b1;
        out_ready = !hold_ready;
        @(posedge clk); #1;
        // Scramble inputs after the handshake; the captured frame must not change.
        in_data = {NUM_CH{DATA_W'($urandom)}};
        ch_mask = NUM_CH'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, "_latency"}, lat, NUM_CH);
        check_eq({tag, "_sum"}, out_sum, es);
        check_eq({tag, "_avg"}, out_avg, ea);
        check_eq({tag, "_in_ready_busy"}, {in_ready, busy}, 2'b01);
        if (hold_ready) begin
            for (int k = 0; k < 5; k++) begin
                @(posedge clk); #1;
                check_eq({tag, "_bp_hold"}, {out_valid, in_ready, busy}, 3'b101);
                check_eq({tag, "_bp_sum"}, out_sum, es);
                check_eq({tag, "_bp_avg"}, out_avg, ea);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end else begin
            in_valid = 1'b0;
        end
        @(posedge clk); #1;
        check_eq({tag, "_after_hs"}, {out_valid, in_ready, busy}, 3'b010);
        check_eq({tag, "_held_sum"}, out_sum, es);
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < NUM_CH; i++) smp[i] = v;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        ch_mask   = '0;
        out_ready = 1'b1;
        msk       = '1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_ctl", {in_ready, out_valid, busy}, 3'b100);
        check_eq("reset_sum", out_sum, 0);
        check_eq("reset_avg", out_avg, 0);
        @(negedge clk);
        rst = 1'b0;

        fill(1);                 run_frame("ones", 1'b0);
        fill(262143);            run_frame("maxpos", 1'b0);
        fill(-262144);           run_frame("maxneg", 1'b0);
        for (int i = 0; i < NUM_CH; i++) smp[i] = i;
        run_frame("ramp_pos", 1'b0);
        for (int i = 0; i < NUM_CH; i++) smp[i] = -i;
        run_frame("ramp_neg", 1'b0);
        fill(5);                 run_frame("backpressure", 1'b1);

        // Reset in the middle of accumulation drops the frame.
        fill(7);
        wait_in_ready("rst_mid");
        @(negedge clk);
        in_data  = pack_frame();
        ch_mask  = msk;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("rst_mid_ctl", {in_ready, out_valid, busy}, 3'b100);
        check_eq("rst_mid_sum", out_sum, 0);
        check_eq("rst_mid_avg", out_avg, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check_eq("rst_mid_no_valid", out_valid, 0);
        fill(3);                 run_frame("threes", 1'b0);

`ifdef BEAM_CHANNEL_MASK_EN
        msk = 16'h00FF;
        fill(2);                 run_frame("mask_lo", 1'b0);
`endif

        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                smp[i] = int'($urandom_range(0, 524287)) - 262144;
            end
`ifdef BEAM_CHANNEL_MASK_EN
            msk = NUM_CH'($urandom);
`else
            msk = '1;
`endif
            run_frame("random", (f % 4) == 3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
